// File: rtl/tone_pkg.sv
// rtl/tone_pkg.sv - shared constants and divisor coercion for the tone datapath
package tone_pkg;

    // Widest divisor the helper function handles; CNT_W must not exceed this.
    localparam int DIV_W = 32;

    localparam int CNT_W_DEFAULT = 28;
    localparam int DIV_DEFAULT   = 16;
    localparam int REST_DIV      = 0;

    // Board clock feeding the divider; note divisors below are derived from it.
    localparam int unsigned BOARD_CLK_HZ = 50_000_000;

    // Natural notes C4..B5, frequencies rounded to whole Hz.
    localparam int unsigned NOTE_C4 = BOARD_CLK_HZ / 262;
    localparam int unsigned NOTE_D4 = BOARD_CLK_HZ / 294;
    localparam int unsigned NOTE_E4 = BOARD_CLK_HZ / 330;
    localparam int unsigned NOTE_F4 = BOARD_CLK_HZ / 349;
    localparam int unsigned NOTE_G4 = BOARD_CLK_HZ / 392;
    localparam int unsigned NOTE_A4 = BOARD_CLK_HZ / 440;
    localparam int unsigned NOTE_B4 = BOARD_CLK_HZ / 494;
    localparam int unsigned NOTE_C5 = BOARD_CLK_HZ / 523;
    localparam int unsigned NOTE_D5 = BOARD_CLK_HZ / 587;
    localparam int unsigned NOTE_E5 = BOARD_CLK_HZ / 659;
    localparam int unsigned NOTE_F5 = BOARD_CLK_HZ / 698;
    localparam int unsigned NOTE_G5 = BOARD_CLK_HZ / 784;
    localparam int unsigned NOTE_A5 = BOARD_CLK_HZ / 880;
    localparam int unsigned NOTE_B5 = BOARD_CLK_HZ / 988;

    // A divisor of 1 cannot make a square wave, so it is promoted to 2.
    function automatic logic [DIV_W-1:0] coerce_div(input logic [DIV_W-1:0] x);
        if (x == DIV_W'(1)) begin
            return DIV_W'(2);
        end
        return x;
    endfunction

endpackage

// File: rtl/tone_clk_divider.sv
// rtl/tone_clk_divider.sv - runtime-programmable square-wave divider with glitch-free divisor switch
module tone_clk_divider
    import tone_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int DEFAULT_DIV = DIV_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [CNT_W-1:0] div_i,
    input  logic             div_load_i,
    output logic             o_clk,
    output logic             period_tick_o,
    output logic             pending_o,
    output logic [CNT_W-1:0] active_div_o
);

    localparam logic [CNT_W-1:0] RESET_DIV = CNT_W'(coerce_div(DIV_W'(DEFAULT_DIV)));
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO       = CNT_W'(2);

    logic [CNT_W-1:0] cnt, cnt_next;
    logic [CNT_W-1:0] active_div, active_next;
    logic [CNT_W-1:0] shadow, shadow_next;
    logic             pending, pending_next;
    logic             o_clk_q, o_clk_next;
    logic             tick_q, tick_next;

    logic [CNT_W-1:0] load_val;
    logic             running;
    logic             wrap;
    logic             apply_now;
    logic             apply_load;
    logic             apply_shadow;

    assign load_val = CNT_W'(coerce_div(DIV_W'(div_i)));

    // Next-state: counter, divisor hand-over at period boundaries, output phase and tick.
    always_comb begin
        running      = en_i && (active_div >= TWO);
        // active_div - 1 only matters while running (active_div >= 2), so no underflow reaches state.
        wrap         = running && (cnt >= active_div - ONE);
        // Outside a running period (rest or disabled) there is no cycle to protect, so apply at once.
        apply_now    = !running || wrap;
        apply_load   = div_load_i && apply_now;
        apply_shadow = !div_load_i && pending && apply_now;

        active_next  = active_div;
        shadow_next  = shadow;
        pending_next = pending;
        if (div_load_i) begin
            shadow_next  = load_val;
            pending_next = !apply_now;
            if (apply_now) begin
                active_next = load_val;
            end
        end else if (apply_shadow) begin
            active_next  = shadow;
            pending_next = 1'b0;
        end

        cnt_next = cnt;
        if (!en_i) begin
            // Frozen while disabled, but a newly applied divisor restarts from a clean period.
            if (apply_load || apply_shadow) begin
                cnt_next = '0;
            end
        end else if (!running || wrap) begin
            cnt_next = '0;
        end else begin
            cnt_next = cnt + ONE;
        end

        o_clk_next = running && (cnt < (active_div >> 1));
        tick_next  = wrap;
    end

    // State register with asynchronous reset to the default divisor.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            active_div <= RESET_DIV;
            shadow     <= '0;
            pending    <= 1'b0;
            o_clk_q    <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            cnt        <= cnt_next;
            active_div <= active_next;
            shadow     <= shadow_next;
            pending    <= pending_next;
            o_clk_q    <= o_clk_next;
            tick_q     <= tick_next;
        end
    end

    assign o_clk         = o_clk_q;
    assign period_tick_o = tick_q;
    assign pending_o     = pending;
    assign active_div_o  = active_div;

endmodule
